alu_request_arbiter: RTL



---
 rtl/alu_request_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - round-robin arbiter sharing one ALU result mux among NUM_REQ requesters
// Optional macro ALU_ARB_FIXED_PRIO_EN: lowest valid index always wins instead of round-robin.
module alu_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4,
  parameter int MAX_SEL     = 12,
  parameter int ALU_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*SEL_W-1:0]  req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [SEL_W-1:0]          mux_address,
  output logic                      alu_start,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  output logic                      busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [SEL_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_error_q, rsp_error_d;
  logic [2:0]          cnt_q, cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [GW-1:0]       last_grant_q, last_grant_d;
  int                  rr_idx;
`endif

  logic                any_valid;
  int                  win_idx;
  logic [SEL_W-1:0]    win_op;

  // Pick the winning requester; later loop iterations override earlier ones, so iterate from lowest priority up
  always_comb begin
    any_valid = 1'b0;
    win_idx   = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid = 1'b1;
        win_idx   = i;
      end
    end
`else
    rr_idx = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rr_idx = (int'(last_grant_q) + i) % NUM_REQ;
      if (req_valid[rr_idx]) begin
        any_valid = 1'b1;
        win_idx   = rr_idx;
      end
    end
`endif
    win_op = req_op[win_idx*SEL_W +: SEL_W];
  end

  // Next-state logic: accept in IDLE, count down the ALU latency in EXEC, hold the response in RESP
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    cnt_d       = cnt_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = GW'(win_idx);
          op_d    = win_op;
          a_d     = req_a[win_idx*DATA_W +: DATA_W];
          b_d     = req_b[win_idx*DATA_W +: DATA_W];
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = GW'(win_idx);
`endif
          if (win_op <= SEL_W'(MAX_SEL)) begin
            state_d     = EXEC;
            cnt_d       = 3'(ALU_LATENCY);
            rsp_error_d = 1'b0;
          end else begin
            // Illegal op never reaches the ALU; answer straight away with an error
            state_d     = RESP;
            rsp_error_d = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rsp_data_d = alu_result;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the select is suppressed for illegal ops so the mux never sees an out-of-range value
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && any_valid && !rst) req_ready[win_idx] = 1'b1;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
    mux_address = '0;
    if (state_q == EXEC || (state_q == RESP && !rsp_error_q)) mux_address = op_q;
    alu_start = (state_q == EXEC) && (cnt_q == 3'(ALU_LATENCY));
    alu_a     = a_q;
    alu_b     = b_q;
    rsp_data  = rsp_data_q;
    rsp_error = rsp_error_q;
    busy      = (state_q != IDLE);
  end

  // State registers with asynchronous reset that drops any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      cnt_q       <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= GW'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      cnt_q       <= cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
